// File: rtl/countdown_timer.sv
// Minutes:seconds countdown timer (00:00-59:59) with set/run/pause/alarm states.
// BCD digits, blink enables and the alarm are decoded from state and sig2hz.
module countdown_timer #(
  parameter int PRESET_MIN = 3,
  parameter int ALARM_SEC  = 10
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       en1hz,
  input  logic       sig2hz,
  input  logic       mode,
  input  logic       select,
  input  logic       adjust,
  output logic [3:0] sec1,
  output logic [2:0] sec10,
  output logic [3:0] min1,
  output logic [2:0] min10,
  output logic       secon,
  output logic       minon,
  output logic       alarm,
  output logic       running
);

  typedef enum logic [2:0] {IDLE, SET_MIN, SET_SEC, RUN, PAUSE, DONE} state_t;

  // Time word packing: {min10[2:0], min1[3:0], sec10[2:0], sec1[3:0]}
  localparam logic [13:0] PRESET_T = {3'(PRESET_MIN / 10), 4'(PRESET_MIN % 10), 7'd0};
  localparam logic [7:0]  ALARM_N  = 8'(ALARM_SEC);

  state_t      state, state_nxt;
  logic [13:0] count, count_nxt;
  logic [13:0] preset, preset_nxt;
  logic [13:0] count_dec;
  logic [7:0]  asec, asec_nxt;
  logic        btn_mode, btn_sel, btn_adj, any_btn;

  // Increment a {tens, ones} BCD field 00..59 with wrap to 00.
  function automatic logic [6:0] inc60(input logic [6:0] v);
    logic [2:0] t;
    logic [3:0] o;
    t = v[6:4];
    o = v[3:0];
    if (o == 4'd9) begin
      o = 4'd0;
      t = (t == 3'd5) ? 3'd0 : t + 3'd1;
    end else begin
      o = o + 4'd1;
    end
    return {t, o};
  endfunction

  function automatic logic [13:0] dec_time(input logic [13:0] v);
    logic [2:0] m10, s10;
    logic [3:0] m1, s1;
    {m10, m1, s10, s1} = v;
    if (s1 != 4'd0) begin
      s1 = s1 - 4'd1;
    end else begin
      s1 = 4'd9;
      if (s10 != 3'd0) begin
        s10 = s10 - 3'd1;
      end else begin
        s10 = 3'd5;
        if (m1 != 4'd0) begin
          m1 = m1 - 4'd1;
        end else begin
          m1  = 4'd9;
          m10 = (m10 == 3'd0) ? 3'd5 : m10 - 3'd1;
        end
      end
    end
    return {m10, m1, s10, s1};
  endfunction

  // Only the highest-priority pulse of a coincident group is acted on.
  assign btn_mode  = mode;
  assign btn_sel   = select & ~mode;
  assign btn_adj   = adjust & ~mode & ~select;
  assign any_btn   = mode | select | adjust;
  assign count_dec = dec_time(count);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= IDLE;
      count  <= PRESET_T;
      preset <= PRESET_T;
      asec   <= 8'd0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      preset <= preset_nxt;
      asec   <= asec_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    preset_nxt = preset;
    asec_nxt   = asec;
    case (state)
      IDLE: begin
        if (btn_mode) begin
          state_nxt = SET_MIN;
        end else if (btn_sel) begin
          if (count != 14'd0) state_nxt = RUN;
        end else if (btn_adj) begin
          count_nxt = preset;
        end
      end
      SET_MIN: begin
        if (btn_mode) begin
          state_nxt = IDLE;
        end else if (btn_sel) begin
          state_nxt = SET_SEC;
        end else if (btn_adj) begin
          count_nxt  = {inc60(count[13:7]), count[6:0]};
          preset_nxt = {inc60(preset[13:7]), preset[6:0]};
        end
      end
      SET_SEC: begin
        if (btn_mode) begin
          state_nxt = IDLE;
        end else if (btn_sel) begin
          state_nxt = SET_MIN;
        end else if (btn_adj) begin
          count_nxt  = {count[13:7], inc60(count[6:0])};
          preset_nxt = {preset[13:7], inc60(preset[6:0])};
        end
      end
      RUN: begin
        // Expiry on the same edge wins over a coincident pause request.
        if (en1hz) begin
          count_nxt = count_dec;
          if (count_dec == 14'd0) begin
            state_nxt = DONE;
            asec_nxt  = 8'd0;
          end else if (btn_sel) begin
            state_nxt = PAUSE;
          end
        end else if (btn_sel) begin
          state_nxt = PAUSE;
        end
      end
      PAUSE: begin
        if (btn_sel) begin
          state_nxt = RUN;
        end else if (btn_adj) begin
          count_nxt = preset;
          state_nxt = IDLE;
        end
      end
      DONE: begin
        if (any_btn || (en1hz && (asec + 8'd1 == ALARM_N))) begin
          count_nxt = preset;
          state_nxt = IDLE;
        end else if (en1hz) begin
          asec_nxt = asec + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    secon   = 1'b1;
    minon   = 1'b1;
    alarm   = 1'b0;
    running = 1'b0;
    case (state)
      SET_MIN: minon = sig2hz;
      SET_SEC: secon = sig2hz;
      RUN:     running = 1'b1;
      PAUSE: begin
        minon = sig2hz;
        secon = sig2hz;
      end
      DONE: begin
        minon = sig2hz;
        secon = sig2hz;
        alarm = sig2hz;
      end
      default: ;
    endcase
  end

  assign {min10, min1, sec10, sec1} = count;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: run/borrow, set, pause, alarm exit, reset.
module tb_countdown_timer;

  logic       CLK = 1'b0;
  logic       RST;
  logic       en1hz, sig2hz, mode, select, adjust;
  logic [3:0] sec1, min1;
  logic [2:0] sec10, min10;
  logic       secon, minon, alarm, running;
  logic [13:0] disp;

  int vectors     = 0;
  int miscompares = 0;

  countdown_timer #(.PRESET_MIN(3), .ALARM_SEC(10)) dut (
    .CLK(CLK), .RST(RST), .en1hz(en1hz), .sig2hz(sig2hz),
    .mode(mode), .select(select), .adjust(adjust),
    .sec1(sec1), .sec10(sec10), .min1(min1), .min10(min10),
    .secon(secon), .minon(minon), .alarm(alarm), .running(running)
  );

  always #5 CLK = ~CLK;

  assign disp = {min10, min1, sec10, sec1};

  function automatic logic [13:0] tm(input int mm, input int ss);
    return {3'(mm / 10), 4'(mm % 10), 3'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic m, input logic s, input logic a, input logic e);
    @(negedge CLK);
    mode = m; select = s; adjust = a; en1hz = e;
    @(negedge CLK);
    mode = 1'b0; select = 1'b0; adjust = 1'b0; en1hz = 1'b0;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic adj(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic blink(input logic v);
    sig2hz = v;
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b0; en1hz = 1'b0; sig2hz = 1'b1; mode = 1'b0; select = 1'b0; adjust = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_time", 32'(disp), 32'(tm(3, 0)));
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_alarm", 32'(alarm), 32'd0);
    chk("rst_secon", 32'(secon), 32'd1);
    chk("rst_minon", 32'(minon), 32'd1);
    RST = 1'b1;

    // Full 3-minute run into DONE, then automatic exit after 10 seconds of alarm
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("run_start", 32'(running), 32'd1);
    tick(1);
    chk("first_dec", 32'(disp), 32'(tm(2, 59)));
    tick(178);
    chk("at_0001", 32'(disp), 32'(tm(0, 1)));
    tick(1);
    chk("done_time", 32'(disp), 32'(tm(0, 0)));
    chk("done_running", 32'(running), 32'd0);
    blink(1'b1);
    chk("done_alarm_hi", 32'(alarm), 32'd1);
    blink(1'b0);
    chk("done_alarm_lo", 32'(alarm), 32'd0);
    chk("done_minon_lo", 32'(minon), 32'd0);
    blink(1'b1);
    tick(9);
    chk("alarm_9s", 32'(alarm), 32'd1);
    tick(1);
    chk("alarm_10s_off", 32'(alarm), 32'd0);
    chk("alarm_10s_time", 32'(disp), 32'(tm(3, 0)));
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("idle_after_done", 32'(running), 32'd0);

    // Set 01:02 with minute wrap
    step(1'b1, 1'b0, 1'b0, 1'b0);
    blink(1'b0);
    chk("setmin_minon", 32'(minon), 32'd0);
    chk("setmin_secon", 32'(secon), 32'd1);
    blink(1'b1);
    adj(58);
    chk("min_wrap", 32'(disp), 32'(tm(1, 0)));
    step(1'b0, 1'b1, 1'b0, 1'b0);
    blink(1'b0);
    chk("setsec_secon", 32'(secon), 32'd0);
    chk("setsec_minon", 32'(minon), 32'd1);
    adj(2);
    chk("set_0102", 32'(disp), 32'(tm(1, 2)));
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("idle_minon", 32'(minon), 32'd1);
    chk("idle_secon", 32'(secon), 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("run2_start", 32'(running), 32'd1);
    tick(3);
    chk("borrow_0100", 32'(disp), 32'(tm(0, 59)));
    tick(54);
    chk("at_0005", 32'(disp), 32'(tm(0, 5)));

    // Pause coinciding with a decrement
    step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("pause_time", 32'(disp), 32'(tm(0, 4)));
    chk("pause_running", 32'(running), 32'd0);
    chk("pause_minon", 32'(minon), 32'd0);
    chk("pause_secon", 32'(secon), 32'd0);
    tick(2);
    chk("pause_frozen", 32'(disp), 32'(tm(0, 4)));
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("pause_adj_time", 32'(disp), 32'(tm(1, 2)));
    chk("pause_adj_minon", 32'(minon), 32'd1);

    // 10:00 -> 09:59 borrow, then mode exits DONE early
    step(1'b1, 1'b0, 1'b0, 1'b0);
    adj(9);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    adj(58);
    chk("set_1000", 32'(disp), 32'(tm(10, 0)));
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1);
    chk("borrow_1000", 32'(disp), 32'(tm(9, 59)));
    tick(599);
    blink(1'b1);
    chk("done2_time", 32'(disp), 32'(tm(0, 0)));
    chk("done2_alarm", 32'(alarm), 32'd1);
    tick(3);
    chk("done2_3s_alarm", 32'(alarm), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("done_mode_alarm", 32'(alarm), 32'd0);
    chk("done_mode_time", 32'(disp), 32'(tm(10, 0)));

    // Coincident buttons: mode wins, adjust discarded
    step(1'b1, 1'b1, 1'b1, 1'b0);
    blink(1'b0);
    chk("prio_minon", 32'(minon), 32'd0);
    chk("prio_time", 32'(disp), 32'(tm(10, 0)));
    chk("prio_running", 32'(running), 32'd0);

    // Zero preset: select in IDLE is ignored
    adj(50);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("zero_time", 32'(disp), 32'(tm(0, 0)));
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("zero_sel_running", 32'(running), 32'd0);
    chk("zero_sel_minon", 32'(minon), 32'd1);
    tick(1);
    chk("zero_idle_hold", 32'(disp), 32'(tm(0, 0)));

    // Asynchronous reset mid-run
    step(1'b1, 1'b0, 1'b0, 1'b0);
    adj(1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1);
    chk("prereset_time", 32'(disp), 32'(tm(0, 59)));
    chk("prereset_running", 32'(running), 32'd1);
    @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    chk("async_rst_time", 32'(disp), 32'(tm(3, 0)));
    chk("async_rst_running", 32'(running), 32'd0);
    chk("async_rst_minon", 32'(minon), 32'd1);
    chk("async_rst_alarm", 32'(alarm), 32'd0);
    #20 RST = 1'b1;
    repeat (2) @(negedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Minutes:seconds countdown timer, range 00:00–59:59, paired with the up-counting 24-hour clock.
- Driven by the same debounced button pulses (mode/select/adjust) and the shared 1 Hz enable / 2 Hz blink signals from the one-second prescaler.
- Produces BCD digits plus per-field display-enable signals for the existing 7-segment decoders, and an alarm output when the count expires.

Parameters:
- PRESET_MIN, 3: preset minutes loaded at reset, range 0–59; preset seconds are 00.
- ALARM_SEC, 10: number of en1hz pulses for which the alarm sounds in DONE before an automatic return to IDLE, range 1–255.

Ports:
- CLK  input  1  system clock.
- RST  input  1  asynchronous, active-low reset.
- en1hz  input  1  one-cycle pulse, once per second.
- sig2hz  input  1  2 Hz square wave, 50% duty, used for blinking.
- mode  input  1  debounced one-cycle button pulse.
- select  input  1  debounced one-cycle button pulse.
- adjust  input  1  debounced one-cycle button pulse.
- sec1  output  4  seconds ones digit, BCD 0–9.
- sec10  output  3  seconds tens digit, 0–5.
- min1  output  4  minutes ones digit, BCD 0–9.
- min10  output  3  minutes tens digit, 0–5.
- secon  output  1  seconds display enable; 1 = digits lit.
- minon  output  1  minutes display enable.
- alarm  output  1  buzzer/LED drive.
- running  output  1  high while in RUN.

Behaviour:
- Reset (RST=0, asynchronous):
  - state = IDLE.
  - count = preset = PRESET_MIN:00.
  - alarm = 0, running = 0, secon = minon = 1, alarm-second counter = 0.
- Registers: all state registers update on the rising edge of CLK. Two 4-digit time registers, count and preset; the digit outputs show count.
- Button priority: if more than one pulse arrives in the same cycle, only the highest is acted on: mode > select > adjust.
- IDLE:
  - mode -> SET_MIN.
  - select -> RUN if count != 00:00; otherwise ignored.
  - adjust -> count := preset.
- SET_MIN:
  - adjust increments minutes in both count and preset; 59 wraps to 00; seconds unaffected.
  - select -> SET_SEC.
  - mode -> IDLE.
  - minon = sig2hz, secon = 1.
- SET_SEC:
  - adjust increments seconds in both count and preset; 59 wraps to 00; no carry into minutes.
  - select -> SET_MIN.
  - mode -> IDLE.
  - secon = sig2hz, minon = 1.
- RUN (running = 1):
  - Each en1hz pulse decrements count by one second with BCD borrow: x0 -> (x-1)9, 00 seconds -> 59 with minutes borrow.
  - When a decrement yields 00:00, state -> DONE on the same edge.
  - select -> PAUSE.
  - mode and adjust are ignored.
  - If en1hz and select coincide, the decrement takes effect and state -> PAUSE (or DONE, if that decrement reached 00:00).
- PAUSE:
  - count frozen.
  - select -> RUN.
  - adjust -> count := preset, state -> IDLE.
  - mode is ignored.
  - minon = secon = sig2hz.
- DONE:
  - count holds 00:00; alarm = sig2hz; minon = secon = sig2hz.
  - The alarm-second counter clears on entry and increments on each en1hz.
  - When it reaches ALARM_SEC, or on any button pulse: count := preset, alarm = 0, state -> IDLE.
- Display enables: secon = minon = 1 in IDLE and RUN.
- Output timing: all outputs are registered or a direct function of state plus sig2hz; there are no combinational paths from the button inputs to the outputs.
- Decrement latency: one clock after en1hz.
- Reset mid-operation: immediate return to the reset values; count returns to PRESET_MIN:00 and any edited preset is lost.
- Invariant: the digit registers never hold non-BCD values or tens digits above 5.

Test Plan:
- Reset with PRESET_MIN=3, then select -> running=1. After 1 en1hz -> 02:59; after 180 en1hz total -> DONE, digits 00:00, alarm follows sig2hz.
- From IDLE: mode, 58 adjusts -> minutes wrap 03 -> 59 -> 00 -> ... ends at 01. Then select, 2 adjusts -> 01:02; minon blinks in SET_MIN, secon blinks in SET_SEC. Then mode, select -> running=1.
- Borrow chain: set 10:00, run, one en1hz -> 09:59. Set 01:00, one en1hz -> 00:59.
- Pause: during RUN, select in the same cycle as en1hz at 00:05 -> 00:04 and PAUSE. Further en1hz -> still 00:04. Adjust -> IDLE with count = preset.
- DONE exit: with ALARM_SEC=10, after 10 en1hz -> alarm=0, IDLE, count = preset. Repeat and press mode after 3 en1hz -> IDLE immediately.
- In IDLE with count 00:00 (preset 00:00), select -> stays IDLE. Assert RST low mid-RUN -> all outputs at reset values asynchronously, without waiting for a clock edge.
